// File: rtl/handshake_constant_buf_pkg.sv
// Shared definitions for the constant/sequence token source and its
// two-slot registered output buffer.
package handshake_constant_buf_pkg;

    // Encoded as {main_valid, skid_valid}
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b10,
        BUF_FULL  = 2'b11
    } buf_state_e;

    // Width of the token index counter; at least one bit even with no wrap.
    function automatic int idx_width(input int unsigned wrap_count);
        return ($clog2(wrap_count + 1) < 1) ? 1 : $clog2(wrap_count + 1);
    endfunction

endpackage

// File: rtl/handshake_skid_buf2.sv
// Generic two-slot registered handshake buffer: full throughput with no
// combinational path between the upstream and downstream valid/ready.
module handshake_skid_buf2
    import handshake_constant_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data
);

    buf_state_e            r_state;
    buf_state_e            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_load_main_in;
    logic                  w_load_main_skid;
    logic                  w_load_skid;

    // Ready depends only on the skid slot; rst masks both sides.
    assign o_ready    = (r_state != BUF_FULL) && !rst;
    assign o_valid    = (r_state != BUF_EMPTY) && !rst;
    assign o_data     = r_main_data;
    assign w_in_fire  = i_valid & o_ready;
    assign w_out_fire = o_valid & i_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            BUF_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt    = BUF_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            BUF_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = BUF_FULL;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt      = BUF_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_data <= '0;
        end else if (w_load_main_in) begin
            r_main_data <= i_data;
        end else if (w_load_main_skid) begin
            r_main_data <= r_skid_data;
        end
    end

    // Skid contents are meaningless unless the state says FULL.
    always_ff @(posedge clk) begin
        if (w_load_skid) begin
            r_skid_data <= i_data;
        end
    end

endmodule

// File: rtl/handshake_constant_buf.sv
// Emits one data token per accepted control token: a constant, or an
// arithmetic sequence VALUE, VALUE+STEP, ... optionally reloading every WRAP_COUNT tokens.
module handshake_constant_buf
    import handshake_constant_buf_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned VALUE      = 1,
    parameter int unsigned STEP       = 0,
    parameter int unsigned WRAP_COUNT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int                    IDX_W    = idx_width(WRAP_COUNT);
    localparam logic [DATA_WIDTH-1:0] VAL_T    = DATA_WIDTH'(VALUE);
    localparam logic [DATA_WIDTH-1:0] STEP_T   = DATA_WIDTH'(STEP);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'((WRAP_COUNT == 0) ? 0 : WRAP_COUNT - 1);

    logic [DATA_WIDTH-1:0] r_cur;
    logic [IDX_W-1:0]      r_idx;
    logic                  w_in_ready;
    logic                  w_in_fire;

    assign ctrl_ready = w_in_ready;
    assign w_in_fire  = ctrl_valid & w_in_ready;

    // The accepted token carries r_cur; the generator advances on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur <= VAL_T;
            r_idx <= '0;
        end else if (w_in_fire && (STEP != 0)) begin
            if ((WRAP_COUNT != 0) && (r_idx == LAST_IDX)) begin
                r_cur <= VAL_T;
                r_idx <= '0;
            end else begin
                r_cur <= r_cur + STEP_T;
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    handshake_skid_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .i_valid(ctrl_valid),
        .o_ready(w_in_ready),
        .i_data (r_cur),
        .o_valid(outs_valid),
        .i_ready(outs_ready),
        .o_data (outs)
    );

endmodule

// File: tb/tb_handshake_constant_buf.sv
// Scoreboard bench: five parameterisations of handshake_constant_buf driven
// with directed token streams and checked against hand-computed values.
module tb_handshake_constant_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  cv;
    logic [4:0]  ordy;
    logic [4:0]  cr;
    logic [4:0]  ov;
    logic [31:0] od0;
    logic [7:0]  od1, od2, od3;
    logic [3:0]  od4;
    logic [31:0] od [5];

    assign od[0] = od0;
    assign od[1] = {24'd0, od1};
    assign od[2] = {24'd0, od2};
    assign od[3] = {24'd0, od3};
    assign od[4] = {28'd0, od4};

    handshake_constant_buf u0 (
        .clk(clk), .rst(rst), .ctrl_valid(cv[0]), .ctrl_ready(cr[0]),
        .outs(od0), .outs_valid(ov[0]), .outs_ready(ordy[0]));

    handshake_constant_buf #(.DATA_WIDTH(8), .VALUE(5), .STEP(0), .WRAP_COUNT(0)) u1 (
        .clk(clk), .rst(rst), .ctrl_valid(cv[1]), .ctrl_ready(cr[1]),
        .outs(od1), .outs_valid(ov[1]), .outs_ready(ordy[1]));

    handshake_constant_buf #(.DATA_WIDTH(8), .VALUE(0), .STEP(1), .WRAP_COUNT(0)) u2 (
        .clk(clk), .rst(rst), .ctrl_valid(cv[2]), .ctrl_ready(cr[2]),
        .outs(od2), .outs_valid(ov[2]), .outs_ready(ordy[2]));

    handshake_constant_buf #(.DATA_WIDTH(8), .VALUE(2), .STEP(3), .WRAP_COUNT(3)) u3 (
        .clk(clk), .rst(rst), .ctrl_valid(cv[3]), .ctrl_ready(cr[3]),
        .outs(od3), .outs_valid(ov[3]), .outs_ready(ordy[3]));

    handshake_constant_buf #(.DATA_WIDTH(4), .VALUE(14), .STEP(1), .WRAP_COUNT(0)) u4 (
        .clk(clk), .rst(rst), .ctrl_valid(cv[4]), .ctrl_ready(cr[4]),
        .outs(od4), .outs_valid(ov[4]), .outs_ready(ordy[4]));

    // exp_tab: values still to be issued; exp_q: values accepted, awaiting output
    logic [31:0] exp_tab [5][$];
    logic [31:0] exp_q   [5][$];
    int          n_in  [5] = '{default: 0};
    int          n_out [5] = '{default: 0};
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b, required %b", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: handshakes sampled mid-cycle, where inputs are settled.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) exp_q[i].delete();
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (ov[i] && ordy[i]) begin
                    n_out[i]++;
                    if (exp_q[i].size() == 0) begin
                        n_chk++;
                        $display("FAIL extra_out%0d: got %0d, required no token", i, od[i]);
                    end else begin
                        chk($sformatf("out%0d", i), od[i], exp_q[i].pop_front());
                    end
                end
                if (cv[i] && cr[i]) begin
                    n_in[i]++;
                    if (exp_tab[i].size() == 0) begin
                        n_chk++;
                        $display("FAIL extra_in%0d: got an accept, required none", i);
                    end else begin
                        exp_q[i].push_back(exp_tab[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic run_seq(input int i, input bit rnd);
        int cyc = 0;
        while ((exp_tab[i].size() != 0 || exp_q[i].size() != 0) && cyc < 200) begin
            cv[i]   = (exp_tab[i].size() != 0);
            ordy[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            cyc++;
        end
        cv[i]   = 1'b0;
        ordy[i] = 1'b0;
        if (cyc >= 200) begin
            n_chk++;
            $display("FAIL timeout%0d: got %0d pending, required 0", i, exp_q[i].size());
        end
    endtask

    initial begin
        rst  = 1'b1;
        cv   = '0;
        ordy = '0;

        // Reset holds everything idle even with a request pending
        cv[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk1("rst_ctrl_ready", cr[0], 1'b0);
            chk1("rst_outs_valid", ov[0], 1'b0);
        end
        step();
        rst = 1'b0;
        exp_tab[0].push_back(32'd1);
        @(negedge clk);
        chk1("post_rst_ready", cr[0], 1'b1);
        chk1("post_rst_valid", ov[0], 1'b0);
        step();
        cv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        chk1("latency_valid", ov[0], 1'b1);
        chk("first_out", od[0], 32'd1);
        step();
        @(negedge clk);
        chk1("drained_valid", ov[0], 1'b0);
        step();

        // Constant mode, back-to-back
        repeat (10) exp_tab[1].push_back(32'd5);
        cv[1]   = 1'b1;
        ordy[1] = 1'b1;
        repeat (10) step();
        cv[1] = 1'b0;
        @(negedge clk);
        #1;
        chk("const_out_count", n_out[1], 10);
        chk("const_in_count", n_in[1], 10);
        step();

        // Backpressure: only two tokens fit while downstream stalls
        for (int v = 0; v < 4; v++) exp_tab[2].push_back(v);
        cv[2]   = 1'b1;
        ordy[2] = 1'b0;
        step();
        step();
        repeat (3) begin
            @(negedge clk);
            chk1("bp_ready", cr[2], 1'b0);
            chk1("bp_valid", ov[2], 1'b1);
            chk("bp_hold", od[2], 32'd0);
            step();
        end
        chk("bp_accepted", n_in[2], 2);
        ordy[2] = 1'b1;
        repeat (3) step();
        cv[2] = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_out_count", n_out[2], 4);
        chk("bp_pending", exp_q[2].size(), 0);
        step();

        // Wrap with random downstream stalls
        exp_tab[3] = '{32'd2, 32'd5, 32'd8, 32'd2, 32'd5, 32'd8, 32'd2};
        run_seq(3, 1'b1);
        chk("wrap_out_count", n_out[3], 7);

        // Modulo overflow in a 4-bit datapath
        exp_tab[4] = '{32'd14, 32'd15, 32'd0, 32'd1};
        run_seq(4, 1'b0);
        chk("ovf_out_count", n_out[4], 4);

        // Reset while FULL discards tokens 4 and 5 and restarts at VALUE
        ordy[2] = 1'b0;
        exp_tab[2].push_back(32'd4);
        exp_tab[2].push_back(32'd5);
        cv[2] = 1'b1;
        step();
        step();
        cv[2] = 1'b0;
        @(negedge clk);
        chk1("full_ready", cr[2], 1'b0);
        chk("full_head", od[2], 32'd4);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk1("rst_pulse_valid", ov[2], 1'b0);
        step();
        rst     = 1'b0;
        ordy[2] = 1'b1;
        cv[2]   = 1'b1;
        exp_tab[2].push_back(32'd0);
        @(negedge clk);
        chk1("after_rst_valid", ov[2], 1'b0);
        chk1("after_rst_ready", cr[2], 1'b1);
        step();
        cv[2] = 1'b0;
        @(negedge clk);
        chk1("restart_valid", ov[2], 1'b1);
        chk("restart_value", od[2], 32'd0);
        step();
        chk("restart_pending", exp_q[2].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
